// File: rtl/dip_switch_debounce.sv
// rtl/dip_switch_debounce.sv - synchronise and whole-word debounce a DIP switch word
//
// Purpose: brings the raw switch word into the clk domain through a
// SYNC_STAGES-deep flop chain. A new word is committed to dout only after
// DEBOUNCE_CYCLES consecutive identical synchronised samples. chg pulses for
// one cycle in the same cycle that dout takes the new value.
//
// Ports:
//   clk       in   1      system clock
//   rst       in   1      synchronous, active-high reset
//   ena       in   1      enable; 0 holds FSM/counters, synchroniser keeps shifting
//   din       in   WIDTH  raw asynchronous switch word
//   dout      out  WIDTH  debounced, committed word
//   chg       out  1      one-cycle commit pulse
//   chg_mask  out  WIDTH  old^new of the last commit
//   chg_cnt   out  8      commits mod 256 (0 unless DIP_CHG_CNT_EN is defined)
//
// Build option: define DIP_CHG_CNT_EN to include the 8-bit commit counter.

module dip_switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             chg,
    output logic [WIDTH-1:0] chg_mask,
    output logic [7:0]       chg_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // Synchroniser: shifts regardless of ena so the FSM sees fresh pins on resume.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    state_t           state_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic             chg_q;
    logic [WIDTH-1:0] chg_mask_q;
    logic             commit_d;

    // Final sample of a full settle window: this edge loads cand into dout.
    assign commit_d = ena && (state_q == ST_SETTLE) && (sync_w == cand_q)
                      && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stable_q   <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            chg_q      <= 1'b0;
            chg_mask_q <= '0;
        end else if (!ena) begin
            // Everything holds except the pulse, which must not stretch.
            chg_q <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sync_w != stable_q) begin
                        cand_q  <= sync_w;
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_SETTLE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (sync_w == cand_q) begin
                        if (commit_d) begin
                            stable_q   <= cand_q;
                            chg_q      <= 1'b1;
                            chg_mask_q <= stable_q ^ cand_q;
                            cnt_q      <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else if (sync_w == stable_q) begin
                        // Bounced back to the committed word: abandon quietly.
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        // A different new word: restart the window on it.
                        cand_q <= sync_w;
                        cnt_q  <= CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign dout     = stable_q;
    assign chg      = chg_q;
    assign chg_mask = chg_mask_q;

`ifdef DIP_CHG_CNT_EN
    logic [7:0] chg_cnt_q;

    // Increments on the commit edge so it moves together with chg and dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_cnt_q <= 8'h00;
        end else if (commit_d) begin
            chg_cnt_q <= chg_cnt_q + 8'h01;
        end
    end

    assign chg_cnt = chg_cnt_q;
`else
    assign chg_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_dip_switch_debounce.sv
// tb/tb_dip_switch_debounce.sv - self-checking bench for dip_switch_debounce

module tb_dip_switch_debounce;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] din;
    logic [7:0] dout;
    logic       chg;
    logic [7:0] chg_mask;
    logic [7:0] chg_cnt;

    int total = 0;
    int bad   = 0;

    // Scoreboard entry: {expected dout, expected chg_mask}
    logic [15:0] sb_q [$];
    int          n_chg   = 0;
    logic [7:0]  exp_cnt = 8'h00;

    dip_switch_debounce dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .din      (din),
        .dout     (dout),
        .chg      (chg),
        .chg_mask (chg_mask),
        .chg_cnt  (chg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_cnt();
`ifdef DIP_CHG_CNT_EN
        return exp_cnt;
`else
        return 8'h00;
`endif
    endfunction

    // Monitor: every chg pulse must match the next queued commit.
    always @(negedge clk) begin
        if (!rst && chg === 1'b1) begin
            n_chg++;
            exp_cnt = exp_cnt + 8'h01;
            if (sb_q.size() == 0) begin
                chk("chg_unexpected", {31'd0, chg}, 32'd0);
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                chk("sb_dout", {24'd0, dout}, {24'd0, e[15:8]});
                chk("sb_mask", {24'd0, chg_mask}, {24'd0, e[7:0]});
                chk("sb_chg_cnt", {24'd0, chg_cnt}, {24'd0, model_cnt()});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        exp_cnt = 8'h00;
        sb_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        logic [7:0] prev;
        logic [7:0] v;

        rst = 1'b1;
        ena = 1'b1;
        din = 8'h00;
        do_reset();

        // Reset state
        chk("rst_dout", {24'd0, dout}, 32'h00);
        chk("rst_chg", {31'd0, chg}, 32'd0);
        chk("rst_mask", {24'd0, chg_mask}, 32'h00);
        chk("rst_cnt", {24'd0, chg_cnt}, 32'h00);

        // First commit: A5 lands at edge 18
        din = 8'hA5;
        sb_q.push_back({8'hA5, 8'hA5});
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("a5_pre_dout", {24'd0, dout}, 32'h00);
            chk("a5_pre_chg", {31'd0, chg}, 32'd0);
        end
        tick();
        chk("a5_dout", {24'd0, dout}, 32'hA5);
        chk("a5_chg", {31'd0, chg}, 32'd1);
        chk("a5_mask", {24'd0, chg_mask}, 32'hA5);
        tick();
        chk("a5_chg_one_cycle", {31'd0, chg}, 32'd0);

        // Glitchy 3C that returns to A5 every 10 cycles: never commits
        base = n_chg;
        for (int r = 0; r < 10; r++) begin
            din = 8'h3C;
            for (int i = 0; i < 9; i++) tick();
            din = 8'hA5;
            tick();
        end
        for (int i = 0; i < 20; i++) tick();
        chk("glitch_dout", {24'd0, dout}, 32'hA5);
        chk("glitch_no_chg", n_chg, base);

        // 3C for 8 cycles then 0F: only 0F commits, 18 edges after the switch
        base = n_chg;
        din = 8'h3C;
        for (int i = 0; i < 8; i++) tick();
        din = 8'h0F;
        sb_q.push_back({8'h0F, 8'hAA});
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("0f_pre_dout", {24'd0, dout}, 32'hA5);
        end
        tick();
        chk("0f_dout", {24'd0, dout}, 32'h0F);
        chk("0f_chg", {31'd0, chg}, 32'd1);
        chk("0f_mask", {24'd0, chg_mask}, 32'hAA);
        tick();
        chk("0f_one_pulse", n_chg, base + 1);

        // FF settling, reset at count 10, then recommits 18 edges after release
        din = 8'hFF;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_dout", {24'd0, dout}, 32'h00);
        chk("rst_mid_chg", {31'd0, chg}, 32'd0);
        chk("rst_mid_mask", {24'd0, chg_mask}, 32'h00);
        exp_cnt = 8'h00;
        sb_q.delete();
        rst = 1'b0;
        sb_q.push_back({8'hFF, 8'hFF});
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("ff_pre_dout", {24'd0, dout}, 32'h00);
        end
        tick();
        chk("ff_dout", {24'd0, dout}, 32'hFF);
        chk("ff_chg", {31'd0, chg}, 32'd1);
        tick();

        // ena=0 for 20 cycles at count 10, commit 6 edges after resume
        din = 8'h00;
        for (int i = 0; i < 12; i++) tick();
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_dout", {24'd0, dout}, 32'hFF);
            chk("hold_chg", {31'd0, chg}, 32'd0);
        end
        ena = 1'b1;
        sb_q.push_back({8'h00, 8'hFF});
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("resume_pre_dout", {24'd0, dout}, 32'hFF);
        end
        tick();
        chk("resume_dout", {24'd0, dout}, 32'h00);
        chk("resume_chg", {31'd0, chg}, 32'd1);
        tick();

        // 257 alternating commits from a fresh reset
        do_reset();
        prev = 8'h00;
        for (int k = 0; k < 257; k++) begin
            v = (k % 2 == 0) ? 8'h5A : 8'h00;
            din = v;
            sb_q.push_back({v, prev ^ v});
            for (int i = 0; i < 18; i++) tick();
            chk("alt_chg", {31'd0, chg}, 32'd1);
            prev = v;
        end
        tick();
        chk("alt_final_cnt", {24'd0, chg_cnt}, {24'd0, model_cnt()});
`ifdef DIP_CHG_CNT_EN
        chk("alt_cnt_257", {24'd0, chg_cnt}, 32'h01);
`else
        chk("alt_cnt_tied", {24'd0, chg_cnt}, 32'h00);
`endif
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
